// File: rtl/video_vga_pkg.sv
// Shared constants and types for the VGA scandoubler horizontal timing path.
// Defaults describe a 28 MHz clock with two VGA lines per 1792-clk TV line.
package video_vga_pkg;

    localparam int unsigned VGA_HPERIOD     = 896;
    localparam int unsigned VGA_HSYNC_BEG   = 0;
    localparam int unsigned VGA_HSYNC_END   = 106;
    localparam int unsigned VGA_SCANOUT_BEG = 160;
    localparam int unsigned VGA_LOCK_CNT    = 4;

    localparam int unsigned VGA_HCOUNT_W    = 10;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        COUNT = 2'd1,
        LOCK  = 2'd2
    } lock_state_e;

    // Window test done as one modular subtraction: positions below beg wrap to a
    // value larger than any legal window length, so no separate lower-bound compare.
    function automatic logic in_window(
        input logic [VGA_HCOUNT_W-1:0] pos,
        input logic [VGA_HCOUNT_W:0]   beg,
        input logic [VGA_HCOUNT_W:0]   len
    );
        logic [VGA_HCOUNT_W:0] w_ofs;
        w_ofs = {1'b0, pos} - beg;
        return w_ofs < len;
    endfunction

endpackage

// File: rtl/video_vga_sync_h_if.sv
// Signal bundle between the VGA horizontal timing generator and its users.
// The timing generator is the master; the scandoubler/pin side is the slave.
interface video_vga_sync_h_if;
    import video_vga_pkg::*;

    logic                    hsync_start;
    logic                    vga_hsync;
    logic                    scanout_start;
    logic                    line_odd;
    logic                    locked;
    logic [VGA_HCOUNT_W-1:0] hcount;

    modport master (
        input  hsync_start,
        output vga_hsync,
        output scanout_start,
        output line_odd,
        output locked,
        output hcount
    );

    modport slave (
        output hsync_start,
        input  vga_hsync,
        input  scanout_start,
        input  line_odd,
        input  locked,
        input  hcount
    );

endinterface

// File: rtl/video_vga_lockdet.sv
// Lock detector: tracks consecutive on-time TV line strobes and reports when the
// incoming line timing has been stable for LOCK_CNT strobes in a row.
module video_vga_lockdet
    import video_vga_pkg::*;
#(
    parameter int unsigned LOCK_CNT = VGA_LOCK_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hsync_start,
    input  logic i_on_time,
    input  logic i_wrap,
    input  logic i_line_odd,
    output logic o_locked
);

    localparam int unsigned  CntW        = $clog2(LOCK_CNT + 1);
    localparam logic         LockOnFirst = (LOCK_CNT <= 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntLast  = CntW'(LOCK_CNT - 1);

    lock_state_e     r_state;
    logic [CntW-1:0] r_goodcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_goodcnt <= '0;
            o_locked  <= 1'b0;
        end else if (i_hsync_start && !i_on_time) begin
            // Early strobe: the counter resyncs, so all lock history is void.
            r_state   <= HUNT;
            r_goodcnt <= '0;
            o_locked  <= 1'b0;
        end else if (i_on_time) begin
            unique case (r_state)
                HUNT: begin
                    r_goodcnt <= CntOne;
                    r_state   <= LockOnFirst ? LOCK : COUNT;
                    o_locked  <= LockOnFirst;
                end
                COUNT: begin
                    r_goodcnt <= r_goodcnt + CntOne;
                    if (r_goodcnt == CntLast) begin
                        r_state  <= LOCK;
                        o_locked <= 1'b1;
                    end
                end
                LOCK: begin
                    o_locked <= 1'b1;
                end
                default: begin
                    r_state   <= HUNT;
                    r_goodcnt <= '0;
                    o_locked  <= 1'b0;
                end
            endcase
        end else if (i_wrap && i_line_odd) begin
            // Second VGA line ended with no strobe: free-run, but timing is no longer trusted.
            r_state   <= HUNT;
            r_goodcnt <= '0;
            o_locked  <= 1'b0;
        end
    end

endmodule

// File: rtl/video_vga_sync_h.sv
// VGA horizontal timing generator: two VGA lines per TV line, resynced to the
// TV-rate hsync_start strobe, with registered sync/scanout decode and lock status.
module video_vga_sync_h
    import video_vga_pkg::*;
#(
    parameter int unsigned HPERIOD     = VGA_HPERIOD,
    parameter int unsigned HSYNC_BEG   = VGA_HSYNC_BEG,
    parameter int unsigned HSYNC_END   = VGA_HSYNC_END,
    parameter int unsigned SCANOUT_BEG = VGA_SCANOUT_BEG,
    parameter int unsigned LOCK_CNT    = VGA_LOCK_CNT
) (
    input  logic               clk,
    input  logic               rst,
    video_vga_sync_h_if.master bus
);

    localparam int unsigned HW = VGA_HCOUNT_W;

    localparam logic [HW-1:0] LastCnt  = HW'(HPERIOD - 1);
    localparam logic [HW-1:0] ScanCnt  = HW'(SCANOUT_BEG);
    localparam logic [HW:0]   HsBeg    = (HW + 1)'(HSYNC_BEG);
    localparam logic [HW:0]   HsLen    = (HW + 1)'(HSYNC_END - HSYNC_BEG);

    logic [HW-1:0] r_hcount;
    logic          r_line_odd;
    logic          r_vga_hsync;
    logic          r_scanout_start;

    logic [HW-1:0] w_hcount_d;
    logic          w_line_odd_d;
    logic          w_wrap;
    logic          w_on_time;
    logic          w_locked;

    always_comb begin
        w_wrap       = (r_hcount == LastCnt);
        w_on_time    = bus.hsync_start && w_wrap && r_line_odd;
        w_hcount_d   = r_hcount + HW'(1);
        w_line_odd_d = r_line_odd;
        if (bus.hsync_start) begin
            w_hcount_d   = '0;
            w_line_odd_d = 1'b0;
        end else if (w_wrap) begin
            w_hcount_d   = '0;
            w_line_odd_d = ~r_line_odd;
        end
    end

    // Outputs decode the next count so they line up with the hcount they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount        <= '0;
            r_line_odd      <= 1'b0;
            r_vga_hsync     <= in_window('0, HsBeg, HsLen);
            r_scanout_start <= 1'b0;
        end else begin
            r_hcount        <= w_hcount_d;
            r_line_odd      <= w_line_odd_d;
            r_vga_hsync     <= in_window(w_hcount_d, HsBeg, HsLen);
            r_scanout_start <= (w_hcount_d == ScanCnt);
        end
    end

    video_vga_lockdet #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lockdet (
        .clk           (clk),
        .rst           (rst),
        .i_hsync_start (bus.hsync_start),
        .i_on_time     (w_on_time),
        .i_wrap        (w_wrap),
        .i_line_odd    (r_line_odd),
        .o_locked      (w_locked)
    );

    assign bus.hcount        = r_hcount;
    assign bus.line_odd      = r_line_odd;
    assign bus.vga_hsync     = r_vga_hsync;
    assign bus.scanout_start = r_scanout_start;
    assign bus.locked        = w_locked;

endmodule
